// File: rtl/spi_note_sender.sv
// rtl/spi_note_sender.sv - transmit-only SPI master packing three note codes into a 32-bit frame
module spi_note_sender #(
  parameter int         CLK_DIV   = 8,
  parameter int         FRAME_GAP = 16,
  parameter logic [7:0] HDR       = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] note1,
  input  logic [7:0] note2,
  input  logic [7:0] note3,
  input  logic       start,
  output logic       ready,
  output logic       done,
  output logic       sck,
  output logic       sdo
);

  localparam int CNT_MAX = (CLK_DIV > FRAME_GAP) ? CLK_DIV : FRAME_GAP;
  localparam int DW      = $clog2(CNT_MAX + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] GAP_LAST = DW'(FRAME_GAP - 1);
  localparam logic [DW-1:0] CNT_ONE  = DW'(1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, GAP} state_t;

  state_t        state, state_nx;
  logic [31:0]   sreg, sreg_nx;
  logic [4:0]    bit_cnt, bit_cnt_nx;
  logic [DW-1:0] div_cnt, div_cnt_nx;
  logic          sck_nx, sdo_nx, ready_nx, done_nx;
  logic          div_end, gap_end, accept;

  assign div_end = (div_cnt == DIV_LAST);
  assign gap_end = (div_cnt == GAP_LAST);
  assign accept  = start && ready;

  // Outputs are registered from next-state values so sck/sdo never see a combinational input path.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      sreg    <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      sck     <= 1'b0;
      sdo     <= 1'b0;
      ready   <= 1'b1;
      done    <= 1'b0;
    end else begin
      state   <= state_nx;
      sreg    <= sreg_nx;
      bit_cnt <= bit_cnt_nx;
      div_cnt <= div_cnt_nx;
      sck     <= sck_nx;
      sdo     <= sdo_nx;
      ready   <= ready_nx;
      done    <= done_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    sreg_nx    = sreg;
    bit_cnt_nx = bit_cnt;
    div_cnt_nx = div_cnt;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nx   = LOW;
          sreg_nx    = {HDR, note3, note2, note1};
          bit_cnt_nx = '0;
          div_cnt_nx = '0;
        end
      end
      LOW: begin
        if (div_end) begin
          state_nx   = HIGH;
          div_cnt_nx = '0;
        end else begin
          div_cnt_nx = div_cnt + CNT_ONE;
        end
      end
      HIGH: begin
        if (div_end) begin
          div_cnt_nx = '0;
          if (bit_cnt == 5'd31) begin
            state_nx = GAP;
          end else begin
            // Falling edge and next data bit launch together.
            state_nx   = LOW;
            sreg_nx    = {sreg[30:0], 1'b0};
            bit_cnt_nx = bit_cnt + 5'd1;
          end
        end else begin
          div_cnt_nx = div_cnt + CNT_ONE;
        end
      end
      GAP: begin
        if (gap_end) begin
          state_nx   = IDLE;
          div_cnt_nx = '0;
        end else begin
          div_cnt_nx = div_cnt + CNT_ONE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    sck_nx   = (state_nx == HIGH);
    sdo_nx   = (state_nx == LOW || state_nx == HIGH) ? sreg_nx[31] : 1'b0;
    ready_nx = (state_nx == IDLE);
    done_nx  = (state == GAP) && (state_nx == IDLE);
  end

endmodule

// File: tb/tb_spi_note_sender.sv
// tb/tb_spi_note_sender.sv - self-checking bench for spi_note_sender with a slave shift-register model
module tb_spi_note_sender;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       reset, start, ready, done, sck, sdo;
  logic [7:0] note1, note2, note3;
  logic       b_reset, b_start, b_ready, b_done, b_sck, b_sdo;
  logic [7:0] b_note1, b_note2, b_note3;

  spi_note_sender dut_a (
    .clk(clk), .reset(reset), .note1(note1), .note2(note2), .note3(note3),
    .start(start), .ready(ready), .done(done), .sck(sck), .sdo(sdo)
  );

  spi_note_sender #(.CLK_DIV(1), .FRAME_GAP(1), .HDR(8'hA5)) dut_b (
    .clk(clk), .reset(b_reset), .note1(b_note1), .note2(b_note2), .note3(b_note3),
    .start(b_start), .ready(b_ready), .done(b_done), .sck(b_sck), .sdo(b_sdo)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    else n_pass++;
  endtask

  // Slave model for DUT A: shifts sdo on each sck rise, latches every 32nd.
  logic        a_prev = 1'b0;
  logic [31:0] a_sh = '0;
  int a_bcnt = 0, a_rises = 0, a_hi_len = 0, a_lo_len = 0, a_hi_bad = 0;
  int a_first_gap = 0, a_done_cnt = 0;
  logic [31:0] a_frames[$];

  always @(negedge clk) begin
    if (reset) begin
      a_prev = 1'b0; a_sh = '0; a_bcnt = 0; a_hi_len = 0; a_lo_len = 0;
    end else begin
      if (done) a_done_cnt++;
      if (sck && !a_prev) begin
        if (a_bcnt == 0) a_first_gap = a_lo_len;
        a_sh = {a_sh[30:0], sdo};
        a_bcnt++; a_rises++; a_hi_len = 1;
        if (a_bcnt == 32) begin a_frames.push_back(a_sh); a_bcnt = 0; end
      end else if (sck) a_hi_len++;
      else if (a_prev) begin
        if (a_hi_len != 8) a_hi_bad++;
        a_lo_len = 1;
      end else a_lo_len++;
      a_prev = sck;
    end
  end

  logic        b_prev = 1'b0;
  logic [31:0] b_sh = '0;
  int b_bcnt = 0, b_rises = 0, b_hi_len = 0, b_lo_len = 0, b_hi_bad = 0, b_lo_bad = 0;
  logic [31:0] b_frames[$];

  always @(negedge clk) begin
    if (b_reset) begin
      b_prev = 1'b0; b_bcnt = 0; b_hi_len = 0; b_lo_len = 0;
    end else begin
      if (b_sck && !b_prev) begin
        if (b_bcnt != 0 && b_lo_len != 1) b_lo_bad++;
        b_sh = {b_sh[30:0], b_sdo};
        b_bcnt++; b_rises++; b_hi_len = 1;
        if (b_bcnt == 32) begin b_frames.push_back(b_sh); b_bcnt = 0; end
      end else if (b_sck) b_hi_len++;
      else if (b_prev) begin
        if (b_hi_len != 1) b_hi_bad++;
        b_lo_len = 1;
      end else b_lo_len++;
      b_prev = b_sck;
    end
  end

  function automatic logic [31:0] last_a();
    return (a_frames.size() > 0) ? a_frames[a_frames.size()-1] : 32'hDEADBEEF;
  endfunction

  task automatic wait_done_a(output int dc);
    dc = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) begin dc = cyc; break; end
    end
    if (dc < 0) $display("FAIL wait_done actual=timeout required=done pulse");
  endtask

  task automatic wait_bits_a(input int n);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (a_bcnt >= n) return;
    end
    $display("FAIL wait_bits actual=timeout required=bit %0d", n);
  endtask

  task automatic send_a(input logic [7:0] n1, n2, n3, output int lat, output logic rdy);
    int t_acc, dc;
    @(posedge clk); #1;
    note1 = n1; note2 = n2; note3 = n3; start = 1'b1;
    t_acc = cyc + 1;
    a_hi_bad = 0;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done_a(dc);
    lat = (dc < 0) ? -1 : dc - t_acc;
    rdy = ready;
  endtask

  typedef struct {
    logic [7:0]  n1, n2, n3;
    logic [31:0] frame;
  } vec_t;
  vec_t vecs [4];

  initial begin
    int lat, rises0, d1, d2, t_acc, nfr;
    logic rdy;
    logic [31:0] fr;
    vecs[0] = '{8'h3C, 8'h40, 8'h43, 32'h0043403C};
    vecs[1] = '{8'hAA, 8'h55, 8'h0F, 32'h000F55AA};
    vecs[2] = '{8'h80, 8'h01, 8'hFE, 32'h00FE0180};
    vecs[3] = '{8'hFF, 8'hFF, 8'hFF, 32'h00FFFFFF};

    reset = 1'b1; start = 1'b0; note1 = '0; note2 = '0; note3 = '0;
    b_reset = 1'b1; b_start = 1'b0; b_note1 = '0; b_note2 = '0; b_note3 = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0; b_reset = 1'b0;
    @(negedge clk);
    chk("rst_sck", sck, 0);     chk("rst_sdo", sdo, 0);
    chk("rst_ready", ready, 1); chk("rst_done", done, 0);
    chk("rst_b_ready", b_ready, 1); chk("rst_b_sck", b_sck, 0);

    // Four consecutive frames: single-frame timing plus slave co-sim of latched notes.
    for (int i = 0; i < 4; i++) begin
      rises0 = a_rises;
      nfr = a_frames.size();
      send_a(vecs[i].n1, vecs[i].n2, vecs[i].n3, lat, rdy);
      fr = last_a();
      chk("latency", lat, 528);
      chk("ready_at_done", rdy, 1);
      chk("rises", a_rises - rises0, 32);
      chk("high_len", a_hi_bad, 0);
      chk("frame_cnt", a_frames.size() - nfr, 1);
      chk("frame", fr, vecs[i].frame);
      chk("cosim_note1", fr[7:0], vecs[i].n1);
      chk("cosim_note2", fr[15:8], vecs[i].n2);
      chk("cosim_note3", fr[23:16], vecs[i].n3);
    end

    // Back-to-back with start held high.
    a_frames.delete();
    @(posedge clk); #1;
    note1 = 8'h01; note2 = 8'h02; note3 = 8'h03; start = 1'b1;
    @(posedge clk); #1;
    note1 = 8'hFF; note2 = 8'h80; note3 = 8'h7F;
    wait_done_a(d1);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done_a(d2);
    chk("b2b_spacing", d2 - d1, 529);
    chk("b2b_count", a_frames.size(), 2);
    chk("b2b_frame1", (a_frames.size() > 0) ? a_frames[0] : 32'hDEADBEEF, 32'h00030201);
    chk("b2b_frame2", last_a(), 32'h007F80FF);
    chk("b2b_gap", a_first_gap >= 24, 1);

    // Busy start and note changes mid-frame.
    a_frames.delete();
    repeat (4) @(posedge clk);
    #1 a_done_cnt = 0;
    note1 = 8'h11; note2 = 8'h22; note3 = 8'h33; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_bits_a(10);
    start = 1'b1; note1 = 8'hEE; note2 = 8'hDD; note3 = 8'hCC;
    @(posedge clk); #1 start = 1'b0;
    wait_done_a(d1);
    repeat (600) @(posedge clk);
    #1;
    chk("busy_frames", a_frames.size(), 1);
    chk("busy_frame", last_a(), 32'h00332211);
    chk("busy_done_cnt", a_done_cnt, 1);
    chk("busy_ready", ready, 1);

    // Reset mid-frame at bit 17.
    a_frames.delete();
    note1 = 8'h5A; note2 = 8'hC3; note3 = 8'h96; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_bits_a(17);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("midrst_sck", sck, 0);     chk("midrst_sdo", sdo, 0);
    chk("midrst_ready", ready, 1); chk("midrst_done", done, 0);
    chk("midrst_no_frame", a_frames.size(), 0);
    rises0 = a_rises;
    send_a(8'h12, 8'h34, 8'h56, lat, rdy);
    chk("postrst_latency", lat, 528);
    chk("postrst_rises", a_rises - rises0, 32);
    chk("postrst_frame", last_a(), 32'h00563412);

    // Boundary parameters on the second instance.
    @(posedge clk); #1;
    b_start = 1'b1;
    t_acc = cyc + 1;
    @(posedge clk); #1 b_start = 1'b0;
    d1 = -1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (b_done) begin d1 = cyc; break; end
    end
    if (d1 < 0) $display("FAIL b_wait_done actual=timeout required=done pulse");
    chk("b_latency", (d1 < 0) ? -1 : d1 - t_acc, 65);
    chk("b_ready_at_done", b_ready, 1);
    chk("b_rises", b_rises, 32);
    chk("b_high_len", b_hi_bad, 0);
    chk("b_low_len", b_lo_bad, 0);
    chk("b_frame", (b_frames.size() > 0) ? b_frames[b_frames.size()-1] : 32'hDEADBEEF, 32'hA5000000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
